shape_processor_sched: RTL and testbench

- Round-robin scheduler that shares one shape_processor SFR port among NUM_REQ requesters.
- Each requester submits a 32-bit CTRL word. The scheduler:
  - pre-checks legality using the shape_processor_modeling functions;
  - writes the word to the processor and checks error;
  - reads back the SFR;
  - returns the read data, or an error, to the granted requester.
- Sits between software-facing command queues and shape_processor's write/read interface.

---
 rtl/shape_processor_modeling.sv | 39 +++
 rtl/shape_processor_sched_pkg.sv | 23 ++
 rtl/shape_processor_sched_rr_arbiter.sv | 42 ++++
 rtl/shape_processor_sched.sv | 125 ++++++++++++
 tb/tb_shape_processor_sched.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/shape_processor_modeling.sv
// Shape processor modeling package.
// Holds the CTRL SFR layout (ctrl_sfr_reg) and the legality helpers used to
// pre-screen commands before they reach the processor.
//   ctrl_sfr_reg : {rsvd[31:16], param[15:8], operation[7:4], shape[3:0]}
//   is_legal_shape / is_legal_operation / is_legal_combination
package shape_processor_modeling;

  typedef struct packed {
    logic [15:0] rsvd;
    logic [7:0]  param;
    logic [3:0]  operation;
    logic [3:0]  shape;
  } ctrl_sfr_reg;

  localparam logic [3:0] SHAPE_CIRCLE   = 4'd0;
  localparam logic [3:0] SHAPE_SQUARE   = 4'd1;
  localparam logic [3:0] SHAPE_TRIANGLE = 4'd2;
  localparam logic [3:0] SHAPE_HEXAGON  = 4'd3;

  localparam logic [3:0] OP_AREA   = 4'd0;
  localparam logic [3:0] OP_PERIM  = 4'd1;
  localparam logic [3:0] OP_SCALE  = 4'd2;
  localparam logic [3:0] OP_ROTATE = 4'd3;

  function automatic logic is_legal_shape(input logic [3:0] shape);
    return shape <= SHAPE_HEXAGON;
  endfunction

  function automatic logic is_legal_operation(input logic [3:0] operation);
    return operation <= OP_ROTATE;
  endfunction

  // Rotating a circle is meaningless; the processor rejects it.
  function automatic logic is_legal_combination(input logic [3:0] shape,
                                                input logic [3:0] operation);
    return !((shape == SHAPE_CIRCLE) && (operation == OP_ROTATE));
  endfunction

endpackage

// File: rtl/shape_processor_sched_pkg.sv
// Scheduler package: FSM state encoding, response record and the
// accept-to-response latency constants.
package shape_processor_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    WRITE    = 3'd2,
    WAIT_ERR = 3'd3,
    READ     = 3'd4,
    CAPTURE  = 3'd5,
    RESP     = 3'd6
  } sched_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } sched_rsp_t;

  localparam int LEGAL_LAT   = 5;
  localparam int ILLEGAL_LAT = 2;

endpackage

// File: rtl/shape_processor_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at or after ptr, wrapping modulo NUM_REQ.
//   req    : request vector
//   ptr    : search start index (register lives in the parent)
//   gnt    : one-hot grant (all zero if no request)
//   gnt_id : index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= NR) sum = sum - NR;
      idx = sum[ID_W-1:0];
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx;
      end
    end
  end

endmodule

// File: rtl/shape_processor_sched.sv
// Round-robin scheduler sharing one shape_processor SFR port among NUM_REQ
// requesters. One command in flight: accept, legality pre-check, write,
// error sample, read back, respond.
//   req_valid/req_data/req_ready : requester side (req_ready one-hot pulse)
//   rsp_valid/rsp_id/rsp_data/rsp_error/rsp_ready : response side
//   sp_write/sp_write_data/sp_read/sp_read_data/sp_error : processor port
module shape_processor_sched
  import shape_processor_modeling::*;
  import shape_processor_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0][31:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [31:0]               rsp_data,
  output logic                      rsp_error,
  input  logic                      rsp_ready,
  output logic                      sp_write,
  output logic [31:0]               sp_write_data,
  output logic                      sp_read,
  input  logic [31:0]               sp_read_data,
  input  logic                      sp_error
);

  sched_state_e        state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_q;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     rr_next;
  logic [NUM_REQ-1:0]  gnt;
  ctrl_sfr_reg         word_q;
  sched_rsp_t          rsp_q;
  logic                legal;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign legal = is_legal_shape(word_q.shape)
              && is_legal_operation(word_q.operation)
              && is_legal_combination(word_q.shape, word_q.operation);

  assign rr_next = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;

  // Accept is a combinational pulse in IDLE; gated by rst_n so nothing is
  // offered to requesters while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;

  assign sp_write      = (state == WRITE);
  assign sp_write_data = sp_write ? word_q : '0;
  assign sp_read       = (state == READ);

  // Read data is forwarded straight out in CAPTURE so the legal path shows
  // the response one cycle after the read strobe; RESP then holds the
  // registered copy while the consumer stalls.
  assign rsp_valid = (state == CAPTURE) || (state == RESP);
  assign rsp_id    = rsp_valid ? id_q : '0;
  assign rsp_data  = (state == CAPTURE) ? sp_read_data :
                     (state == RESP)    ? rsp_q.data   : '0;
  assign rsp_error = (state == RESP) ? rsp_q.err : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      word_q <= '0;
      rsp_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            word_q <= req_data[gnt_id];
            id_q   <= gnt_id;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (legal) begin
            state <= WRITE;
          end else begin
            rsp_q <= '{data: 32'd0, err: 1'b1};
            state <= RESP;
          end
        end
        WRITE: state <= WAIT_ERR;
        WAIT_ERR: begin
          if (sp_error) begin
            rsp_q <= '{data: 32'd0, err: 1'b1};
            state <= RESP;
          end else begin
            state <= READ;
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          rsp_q <= '{data: sp_read_data, err: 1'b0};
          if (rsp_ready) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end else begin
            state  <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_processor_sched.sv
module tb_shape_processor_sched;
  import shape_processor_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [31:0]              rsp_data;
  logic                     rsp_error;
  logic                     rsp_ready;
  logic                     sp_write;
  logic [31:0]              sp_write_data;
  logic                     sp_read;
  logic [31:0]              sp_read_data;
  logic                     sp_error;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mptr    = 0;
  logic        err_plan;
  logic [31:0] rd_val;

  always #5 clk = ~clk;

  shape_processor_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_ready(rsp_ready),
    .sp_write(sp_write), .sp_write_data(sp_write_data), .sp_read(sp_read),
    .sp_read_data(sp_read_data), .sp_error(sp_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Processor stand-in: read data and error are only meaningful the cycle
  // after the matching strobe; any other cycle carries the opposite value.
  task automatic tick();
    logic pr, pw;
    pr = sp_read;
    pw = sp_write;
    @(posedge clk);
    #1;
    sp_read_data = pr ? rd_val : ~rd_val;
    sp_error     = pw ? err_plan : ~err_plan;
    #1;
  endtask

  // Legality rules: shape 0..3, operation 0..3, no rotate (3) of a circle (0).
  function automatic logic legal_word(input logic [31:0] w);
    int sh, op;
    sh = int'(w[3:0]);
    op = int'(w[7:4]);
    return (sh < 4) && (op < 4) && !(sh == 0 && op == 3);
  endfunction

  // kind: 0 legal, 1 bad shape, 2 bad operation, 3 circle+rotate
  function automatic logic [31:0] gen_word(input int kind);
    int sh, op;
    logic [31:0] w;
    w = $urandom;
    case (kind)
      0: begin
        sh = $urandom_range(0, 3);
        op = $urandom_range(0, 3);
        if (sh == 0 && op == 3) op = $urandom_range(0, 2);
      end
      1: begin sh = $urandom_range(4, 15); op = $urandom_range(0, 3); end
      2: begin sh = $urandom_range(0, 3);  op = $urandom_range(4, 15); end
      default: begin sh = 0; op = 3; end
    endcase
    w[3:0] = 4'(sh);
    w[7:4] = 4'(op);
    return w;
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] mask);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(mptr + k) % NUM_REQ]) return (mptr + k) % NUM_REQ;
    return 0;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    chk({tag, "_sp_write"}, 32'(sp_write), 32'd0);
    chk({tag, "_sp_write_data"}, sp_write_data, 32'd0);
    chk({tag, "_sp_read"}, 32'(sp_read), 32'd0);
  endtask

  // One command from acceptance to handshake. stall = cycles rsp_ready is
  // held low once the response is up; rst_at = cycle after accept at which
  // reset is applied (-1 for none).
  task automatic transact(input logic [NUM_REQ-1:0] vmask, input int kind,
                          input logic eplan, input int stall, input int rst_at);
    int          id, lat;
    logic        lg, exp_err;
    logic [31:0] w, exp_data;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    err_plan = eplan;
    rd_val   = $urandom;
    for (int i = 0; i < NUM_REQ; i++) req_data[i] = gen_word($urandom_range(0, 3));
    id = pick(vmask);
    req_data[id] = gen_word(kind);
    w        = req_data[id];
    lg       = legal_word(w);
    lat      = !lg ? ILLEGAL_LAT : (eplan ? 4 : LEGAL_LAT);
    exp_err  = !lg || eplan;
    exp_data = exp_err ? 32'd0 : rd_val;
    rsp_ready = (stall == 0);
    req_valid = vmask;
    #1;
    chk("accept_onehot", 32'(req_ready), 32'd1 << id);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k == rst_at) begin
        chk("pre_rst_sp_write", 32'(sp_write), 32'(lg && k == 2));
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        tick();
        req_valid = '0;
        rst_n = 1'b1;
        mptr = 0;
        for (int c = 0; c < 4; c++) begin
          tick();
          chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
          chk("post_rst_sp_write", 32'(sp_write), 32'd0);
          chk("post_rst_sp_read", 32'(sp_read), 32'd0);
        end
        return;
      end
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      chk("sp_write", 32'(sp_write), 32'(lg && k == 2));
      chk("sp_write_data", sp_write_data, (lg && k == 2) ? w : 32'd0);
      chk("sp_read", 32'(sp_read), 32'(lg && !eplan && k == 4));
      chk("rsp_valid", 32'(rsp_valid), 32'(k == lat));
    end
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_error", 32'(rsp_error), 32'(exp_err));
    for (int s = 1; s <= stall; s++) begin
      tick();
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_id", 32'(rsp_id), 32'(id));
      chk("stall_rsp_data", rsp_data, exp_data);
      chk("stall_rsp_error", 32'(rsp_error), 32'(exp_err));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_sp_idle", 32'({sp_write, sp_read}), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    mptr = (id + 1) % NUM_REQ;
    req_valid = '0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    sp_read_data = '0; sp_error = 1'b0; err_plan = 1'b0; rd_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    check_outputs_zero("post_reset_idle");

    // 1: legal word from requester 0
    transact(4'b0001, 0, 1'b0, 0, -1);
    // 2: illegal combination from requester 2
    transact(4'b0100, 3, 1'b0, 0, -1);
    // 3: legal word, processor reports error; requester 3 leaves pointer at 0
    transact(4'b1000, 0, 1'b1, 0, -1);
    // 4: all requesters continuously valid: order 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) transact(4'b1111, 0, 1'b0, 0, -1);
    // 5: response backpressure for 10 cycles, legal then illegal
    transact(4'b1111, 0, 1'b0, 10, -1);
    transact(4'b0110, 1, 1'b0, 10, -1);
    // randomized mix
    for (int i = 0; i < 40; i++)
      transact(NUM_REQ'($urandom_range(1, 15)),
               ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
               1'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 3)), -1);
    // 6: reset during the write strobe; pointer moved off 0 first
    transact(4'b0100, 0, 1'b0, 0, -1);
    transact(4'b1111, 0, 1'b0, 0, 2);
    transact(4'b1111, 0, 1'b0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
